aes_key_expand_seq: RTL
=======================

Name: aes_key_expand_seq

Overview:
- Sequential AES key-expansion engine. It sits directly upstream of the AES round datapath.
- Accepts a 128/192/256-bit cipher key and produces the Nr+1 round keys in order, one 128-bit key per handshake.
- Generates one 32-bit schedule word per cycle using a sliding window of the last Nk words.
- Consumer applies backpressure through a valid/ready handshake.

Parameters:
- N, 128, key width in bits (128/192/256).
- Nr, 10, number of rounds (10/12/14).
- Nk, 4, key length in 32-bit words (4/6/8).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin expansion; sampled only in IDLE.
- key  input  N  cipher key; key[N-1:N-32] is w[0] (FIPS-197 byte order); sampled on the start cycle.
- busy  output  1  high from the cycle after start until done.
- rk_valid  output  1  rk/rk_idx/rk_last hold a valid round key.
- rk_ready  input  1  consumer accepts the round key when rk_valid && rk_ready.
- rk  output  128  round key; rk[127:96]=w[4r], rk[31:0]=w[4r+3].
- rk_idx  output  4  round index r, 0..Nr.
- rk_last  output  1  high with rk_idx==Nr.
- done  output  1  one-cycle pulse after the final round key is accepted.

Behaviour:
- Reset (async, rst_n=0): every output is 0; state=IDLE; all counters, window, assembly buffer and rcon are cleared.
- FSM states: IDLE, GEN, DRAIN.
- IDLE -> GEN on start: latch key into the window, set word counter i=0, kc=0, rcon=8'h01, and set busy next cycle. start in any other state is ignored.
- GEN: produces one word per cycle into a 4-word assembly buffer, unless stalled.
  - For i<Nk: word = key word i.
  - Otherwise: temp = w[i-1].
    - If kc==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon), with reduction poly 8'h1B.
    - Else if Nk>6 and kc==4: temp = SubWord(temp).
    - Then w[i] = w[i-Nk] ^ temp.
  - kc wraps Nk-1 -> 0. i increments 0..4(Nr+1)-1.
- Output register:
  - When the 4th word of a group is produced and the output register is empty or being accepted that cycle, the group moves to rk and rk_valid=1 next cycle. Otherwise generation stalls; no word is produced and no state changes.
  - rk, rk_idx and rk_last are held stable while rk_valid && !rk_ready.
- Latency and throughput:
  - start at cycle T -> first rk_valid at T+5.
  - With rk_ready held high, one round key every 4 cycles.
- GEN -> DRAIN once word 4(Nr+1)-1 is transferred to the output register.
- DRAIN -> IDLE when the final key is accepted. done=1 for one cycle on that transition; busy=0 the same cycle.
- S-box: 4 combinational byte lookups (FIPS-197 table) for SubWord.
- Nk=4 uses only the kc==0 branch. Nk=6 window is 6 words. Nk=8 applies the extra SubWord at kc==4.
- Boundaries:
  - rk_ready asserted without rk_valid: no effect.
  - start in the same cycle as done (DRAIN->IDLE): ignored; it must be re-issued in IDLE.
  - Reset mid-expansion: aborts immediately; no done pulse; rk_valid=0.

Optional Feature:
- Macro: AES_KEYEXP_PARITY_EN.
- Defined: adds output port rk_par [15:0], the odd parity of each byte of rk (rk_par[k] covers rk[8k+7:8k]). It is registered with rk and is 0 in reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. N=128, key=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1, start pulse:
   - rk_idx0 = the key, at start+5.
   - rk_idx1 = a0fafe1788542cb123a339392a6c7605.
   - rk_idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1.
   - done one cycle after rk_idx10 is accepted.
2. N=192, Nr=12, Nk=6, key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
   - 13 keys.
   - rk_idx12 = e98ba06f448c773c8ecc720401002202.
3. N=256, Nr=14, Nk=8, key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
   - rk_idx14 = fe4890d1e6188d0b046df344706c631e.
   - Checks the kc==4 SubWord path.
4. Backpressure: test 1 with rk_ready random (50%):
   - rk is stable while stalled.
   - The key sequence is identical to test 1; no key is lost or duplicated.
5. Reset mid-run: rst_n=0 asynchronously after rk_idx3:
   - All outputs 0 immediately.
   - A new start reproduces the test 1 sequence from rk_idx0.
6. start while busy (during GEN and DRAIN):
   - Ignored; the sequence and done timing are unchanged.
   - With AES_KEYEXP_PARITY_EN, rk_par matches the byte odd parity for every key.

Source files
------------

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key expansion: one schedule word per cycle, round keys out over valid/ready.
// Optional AES_KEYEXP_PARITY_EN adds rk_par, the per-byte odd parity of rk.
module aes_key_expand_seq #(
   parameter int N  = 128,
   parameter int Nr = 10,
   parameter int Nk = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   key,
   output logic           busy,
   output logic           rk_valid,
   input  logic           rk_ready,
   output logic [127:0]   rk,
   output logic [3:0]     rk_idx,
   output logic           rk_last,
   output logic           done
`ifdef AES_KEYEXP_PARITY_EN
   , output logic [15:0]  rk_par
`endif
);

   localparam int NW = 4 * (Nr + 1);
   localparam int IW = 6;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_GEN, S_DRAIN} state_t;

   state_t         r_state, w_state_nx;
   logic [31:0]    r_win [Nk];
   logic [31:0]    r_asm [4];
   logic [IW-1:0]  r_i;
   logic [2:0]     r_kc;
   logic [7:0]     r_rcon;
   logic           r_busy, r_vld, r_last, r_done;
   logic [127:0]   r_rk;
   logic [3:0]     r_idx;
   logic [15:0]    r_par;

   logic           w_grp_end, w_stall, w_adv, w_accept, w_final, w_start, w_key_ph;
   logic [31:0]    w_prev, w_temp, w_word;
   logic [127:0]   w_rk_nx;

   assign w_grp_end = (r_i[1:0] == 2'd3);
   assign w_stall   = w_grp_end && r_vld && !rk_ready;
   assign w_adv     = (r_state == S_GEN) && !w_stall;
   assign w_accept  = r_vld && rk_ready;
   assign w_final   = (r_i == IW'(NW - 1));
   // start is also ignored in the done cycle so it must be re-issued once truly idle
   assign w_start   = (r_state == S_IDLE) && start && !r_done;
   assign w_key_ph  = (r_i < IW'(Nk));
   assign w_rk_nx   = {r_asm[0], r_asm[1], r_asm[2], w_word};

   // The window rotates even during the key phase, so r_win[0] is always w[i-Nk]
   // (or key word i) and r_win[Nk-1] is always w[i-1].
   always_comb begin
      w_prev = r_win[Nk-1];
      w_temp = w_prev;
      if (r_kc == 3'd0)
         w_temp = subw({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
      else if (Nk > 6 && r_kc == 3'd4)
         w_temp = subw(w_prev);
      w_word = w_key_ph ? r_win[0] : (r_win[0] ^ w_temp);
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nx = S_GEN;
         S_GEN:   if (w_adv && w_grp_end && w_final) w_state_nx = S_DRAIN;
         S_DRAIN: if (w_accept) w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         for (int k = 0; k < Nk; k++) r_win[k] <= '0;
         for (int k = 0; k < 4; k++)  r_asm[k] <= '0;
         r_i    <= '0;
         r_kc   <= '0;
         r_rcon <= '0;
         r_busy <= 1'b0;
         r_vld  <= 1'b0;
         r_last <= 1'b0;
         r_done <= 1'b0;
         r_rk   <= '0;
         r_idx  <= '0;
         r_par  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_done  <= 1'b0;
         if (w_start) begin
            for (int k = 0; k < Nk; k++) r_win[k] <= key[N-1-32*k -: 32];
            r_i    <= '0;
            r_kc   <= '0;
            r_rcon <= 8'h01;
            r_busy <= 1'b1;
         end
         if (w_adv) begin
            for (int k = 0; k < Nk - 1; k++) r_win[k] <= r_win[k+1];
            r_win[Nk-1]      <= w_word;
            r_asm[r_i[1:0]]  <= w_word;
            r_i              <= r_i + IW'(1);
            r_kc             <= (r_kc == 3'(Nk - 1)) ? 3'd0 : r_kc + 3'd1;
            if (!w_key_ph && r_kc == 3'd0)
               r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);
         end
         if (w_adv && w_grp_end) begin
            r_vld  <= 1'b1;
            r_rk   <= w_rk_nx;
            r_idx  <= r_i[5:2];
            r_last <= w_final;
            for (int b = 0; b < 16; b++) r_par[b] <= ^w_rk_nx[8*b +: 8];
         end else if (w_accept) begin
            r_vld <= 1'b0;
         end
         if (r_state == S_DRAIN && w_accept) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end
   end

   assign busy     = r_busy;
   assign rk_valid = r_vld;
   assign rk       = r_rk;
   assign rk_idx   = r_idx;
   assign rk_last  = r_last;
   assign done     = r_done;
`ifdef AES_KEYEXP_PARITY_EN
   assign rk_par   = r_par;
`else
   logic w_par_unused;
   assign w_par_unused = ^r_par;
`endif

endmodule
